// File: rtl/mont_mul_serial.sv
// Radix-2 bit-serial Montgomery multiplier: o_montgomery = a*b*2^-LOG_R mod (2^255-19).
// Define MONT_OPERAND_REDUCE_EN to add a PRE state that reduces operands >= N before the loop.
module mont_mul_serial #(
  parameter int LOG_R = 256,
  parameter int WIDTH = 255
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_montgomery,
  output logic             o_finished
);

  localparam int SW = WIDTH + 2;
  localparam int CW = $clog2(LOG_R + 1);
  localparam logic [SW-1:0] MODN = {2'b00, {WIDTH{1'b1}}} - SW'(18);
  localparam logic [CW-1:0] LAST = CW'(LOG_R - 1);

  typedef enum logic [2:0] {IDLE, PRE, LOOP, REDUCE, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [SW-1:0]    s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             fin_q, fin_d;
  logic [SW-1:0]    t;
  logic [SW-1:0]    u;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      fin_q   <= fin_d;
    end
  end

  // S < 2N keeps t + q*N below 4N < 2^257, so the iteration fits in SW bits.
  // A is consumed LSB-first by shifting; bits past WIDTH read as zero.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    fin_d   = 1'b0;
    t       = s_q + (a_q[0] ? {2'b00, b_q} : '0);
    u       = t + (t[0] ? MODN : '0);
    case (state_q)
      IDLE: begin
        if (i_start) begin
          a_d   = i_a;
          b_d   = i_b;
          s_d   = '0;
          cnt_d = '0;
`ifdef MONT_OPERAND_REDUCE_EN
          state_d = PRE;
`else
          state_d = LOOP;
`endif
        end
      end
`ifdef MONT_OPERAND_REDUCE_EN
      PRE: begin
        if ({2'b00, a_q} >= MODN) a_d = a_q - MODN[WIDTH-1:0];
        if ({2'b00, b_q} >= MODN) b_d = b_q - MODN[WIDTH-1:0];
        state_d = LOOP;
      end
`endif
      LOOP: begin
        s_d   = u >> 1;
        a_d   = a_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = REDUCE;
      end
      REDUCE: begin
        if (s_q >= MODN) s_d = s_q - MODN;
        state_d = DONE;
      end
      DONE: begin
        res_d   = s_q[WIDTH-1:0];
        fin_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_montgomery = res_q;
  assign o_finished   = fin_q;

endmodule

// File: tb/tb_mont_mul_serial.sv
// Directed-vector bench for mont_mul_serial using identities built on R mod N = 38.
// Build with MONT_OPERAND_REDUCE_EN to exercise the operand pre-reduction path.
module tb_mont_mul_serial;

  localparam int WIDTH = 255;
  localparam int LOG_R = 256;
  localparam logic [WIDTH-1:0] NMOD = {WIDTH{1'b1}} - 255'd18;
`ifdef MONT_OPERAND_REDUCE_EN
  localparam int EXP_LAT = LOG_R + 3;
`else
  localparam int EXP_LAT = LOG_R + 2;
`endif

  logic             clk = 1'b0;
  logic             rstN;
  logic             start;
  logic [WIDTH-1:0] ia, ib;
  logic [WIDTH-1:0] mont;
  logic             fin;
  int               total = 0;
  int               bad = 0;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  mont_mul_serial #(.LOG_R(LOG_R), .WIDTH(WIDTH)) dut (
    .i_clk(clk),
    .i_rst_n(rstN),
    .i_start(start),
    .i_a(ia),
    .i_b(ib),
    .o_montgomery(mont),
    .o_finished(fin)
  );

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Presents one request; returns #1 after the edge that sampled it, with the operand bus scrambled.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    ia = a;
    ib = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ia = ~a;
    ib = ~b;
  endtask

  // Counts edges until o_finished; optionally injects stray starts at given cycles.
  task automatic waitFinish(input int pulse1, input int pulse2, output int lat, output logic [WIDTH-1:0] res);
    logic [WIDTH-1:0] prevMont;
    int changed;
    prevMont = mont;
    changed = 0;
    lat = -1;
    res = mont;
    for (int k = 1; k <= 400 && lat < 0; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (fin) begin
        lat = k;
        res = mont;
      end else begin
        if (mont !== prevMont) changed++;
        if (k == pulse1 || k == pulse2) begin
          ia = 255'd1444;
          ib = 255'd1444;
          start = 1'b1;
        end
      end
    end
    checkInt("result held before done", changed, 0);
  endtask

  task automatic checkPulseEnd();
    @(posedge clk);
    #1;
    checkInt("finished pulse width", int'(fin), 0);
  endtask

  task automatic checkSilence(input int cycles);
    int seen;
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      if (fin) seen++;
    end
    checkInt("unexpected finished", seen, 0);
  endtask

  task automatic runVec(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp);
    int lat;
    logic [WIDTH-1:0] res;
    applyStimulus(a, b);
    waitFinish(0, 0, lat, res);
    checkInt("latency", lat, EXP_LAT);
    checkOutput("result", res, exp);
    checkPulseEnd();
  endtask

  initial begin
    int lat;
    logic [WIDTH-1:0] res;

    vecs[0]  = '{255'd38, 255'd5, 255'd5};
    vecs[1]  = '{255'd0, NMOD - 255'd1, 255'd0};
    vecs[2]  = '{255'd38, NMOD - 255'd1, NMOD - 255'd1};
    vecs[3]  = '{255'd76, 255'd5, 255'd10};
    vecs[4]  = '{255'd114, NMOD - 255'd1, NMOD - 255'd3};
    vecs[5]  = '{255'd76, (NMOD + 255'd1) >> 1, 255'd1};
    vecs[6]  = '{255'd1444, 255'd1, 255'd38};
    vecs[7]  = '{255'd1444, 255'd1444, 255'd54872};
    vecs[8]  = '{255'd1444, NMOD - 255'd1, NMOD - 255'd38};
    vecs[9]  = '{255'd76, 255'd1 << 254, 255'd19};
    vecs[10] = '{NMOD - 255'd38, NMOD - 255'd1, 255'd1};
    vecs[11] = '{255'd5, 255'd38, 255'd5};

    rstN = 1'b0;
    start = 1'b0;
    ia = '0;
    ib = '0;
    repeat (3) @(posedge clk);
    #1;
    checkInt("reset finished", int'(fin), 0);
    checkOutput("reset result", mont, '0);
    rstN = 1'b1;

    for (int i = 0; i < 12; i++) runVec(vecs[i].a, vecs[i].b, vecs[i].exp);

    // Result must persist between requests.
    repeat (20) @(posedge clk);
    #1;
    checkOutput("result held idle", mont, vecs[11].exp);

    $display("[TB] stray starts during an operation");
    applyStimulus(255'd38, 255'd7);
    waitFinish(10, 200, lat, res);
    checkInt("stray latency", lat, EXP_LAT);
    checkOutput("stray result", res, 255'd7);
    checkSilence(300);

    $display("[TB] back-to-back requests");
    applyStimulus(255'd38, 255'd9);
    waitFinish(0, 0, lat, res);
    checkInt("b2b first latency", lat, EXP_LAT);
    checkOutput("b2b first result", res, 255'd9);
    ia = 255'd1444;
    ib = 255'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ia = '0;
    ib = '0;
    waitFinish(0, 0, lat, res);
    checkInt("b2b second latency", lat, EXP_LAT);
    checkOutput("b2b second result", res, 255'd76);
    checkPulseEnd();

    $display("[TB] reset mid-operation");
    applyStimulus(255'd38, 255'd13);
    repeat (99) @(posedge clk);
    #1;
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
    checkSilence(300);
    checkOutput("result after abort", mont, '0);
    runVec(255'd38, 255'd11, 255'd11);

`ifdef MONT_OPERAND_REDUCE_EN
    $display("[TB] unreduced operands");
    runVec(NMOD + 255'd5, 255'd38, 255'd5);
    runVec(255'd38, NMOD + 255'd7, 255'd7);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
